// File: rtl/lin_radix_encoder_pkg.sv
// Shared constants and types for the radix-encoded activation transmitter.
package lin_radix_encoder_pkg;

    localparam int LIN_SIZE = 84;
    localparam int ACT_BITS = 3;

    // Plane index width; a single-plane configuration still needs one bit.
    function automatic int step_width(input int act_bits);
        return (act_bits > 1) ? $clog2(act_bits) : 1;
    endfunction

    localparam int STEP_BITS = step_width(ACT_BITS);
    localparam int IDX_BITS  = $clog2(LIN_SIZE);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } enc_state_e;

endpackage

// File: rtl/lin_radix_encoder_if.sv
// Activation input and bit-plane output bundle of the radix encoder.
// Both sides use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; valid never waits on ready and the
// payload holds steady while valid is high and ready is low.
interface lin_radix_encoder_if #(
    parameter int LIN_SIZE  = lin_radix_encoder_pkg::LIN_SIZE,
    parameter int ACT_BITS  = lin_radix_encoder_pkg::ACT_BITS,
    parameter int STEP_BITS = lin_radix_encoder_pkg::step_width(ACT_BITS)
) ();
    import lin_radix_encoder_pkg::*;

    logic                 act_valid;
    logic                 act_ready;
    logic [ACT_BITS-1:0]  act_data;
    logic                 act_last;
    logic                 plane_valid;
    logic                 plane_ready;
    logic [LIN_SIZE-1:0]  plane_data;
    logic [STEP_BITS-1:0] plane_step;
    logic                 plane_last;
    logic                 busy;
    enc_state_e           dbg_state;

    // Encoder side.
    modport master (
        input  act_valid, act_data, act_last, plane_ready,
        output act_ready, plane_valid, plane_data, plane_step, plane_last,
        output busy, dbg_state
    );

    // Producer / linear-unit side.
    modport slave (
        output act_valid, act_data, act_last, plane_ready,
        input  act_ready, plane_valid, plane_data, plane_step, plane_last,
        input  busy, dbg_state
    );

endinterface

// File: rtl/lin_radix_encoder.sv
// Collects a frame of activations and replays it as bit-planes, MSB first.
module lin_radix_encoder #(
    parameter int LIN_SIZE  = lin_radix_encoder_pkg::LIN_SIZE,
    parameter int ACT_BITS  = lin_radix_encoder_pkg::ACT_BITS,
    parameter int STEP_BITS = lin_radix_encoder_pkg::step_width(ACT_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lin_radix_encoder_if.master  bus
);
    import lin_radix_encoder_pkg::*;

    localparam int                   IDX_W    = (LIN_SIZE > 1) ? $clog2(LIN_SIZE) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(LIN_SIZE - 1);
    localparam logic [STEP_BITS-1:0] STEP_TOP = STEP_BITS'(ACT_BITS - 1);

    enc_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic                 busy_q, busy_d;
    logic [ACT_BITS-1:0]  buf_q [LIN_SIZE];
    logic [ACT_BITS-1:0]  buf_d [LIN_SIZE];

    logic act_hs, plane_hs, frame_end, plane_done;

    assign act_hs     = (state_q == FILL) && bus.act_valid;
    assign plane_hs   = (state_q == SEND) && bus.plane_ready;
    assign frame_end  = act_hs && ((idx_q == IDX_LAST) || bus.act_last);
    assign plane_done = plane_hs && (step_q == '0);

    // Frame sequencing: write index in FILL, plane countdown in SEND.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        busy_d  = busy_q;
        if (act_hs) begin
            busy_d = 1'b1;
            if (frame_end) begin
                state_d = SEND;
                idx_d   = '0;
                step_d  = STEP_TOP;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (plane_hs) begin
            if (plane_done) begin
                state_d = FILL;
                step_d  = STEP_TOP;
                busy_d  = 1'b0;
            end else begin
                step_d = step_q - 1'b1;
            end
        end
    end

    // Buffer update: capture one word per handshake, wipe after the last plane
    // so a short next frame sees zeros in the entries it never writes.
    always_comb begin
        for (int i = 0; i < LIN_SIZE; i++) begin
            buf_d[i] = buf_q[i];
            if (plane_done) begin
                buf_d[i] = '0;
            end else if (act_hs && (idx_q == IDX_W'(i))) begin
                buf_d[i] = bus.act_data;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            step_q  <= STEP_TOP;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
        end
    end

    // Activation buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LIN_SIZE; i++) buf_q[i] <= '0;
        end else begin
            for (int i = 0; i < LIN_SIZE; i++) buf_q[i] <= buf_d[i];
        end
    end

    // Plane select: bit step of every stored activation.
    for (genvar g = 0; g < LIN_SIZE; g++) begin : g_plane
        assign bus.plane_data[g] = buf_q[g][step_q];
    end

    assign bus.act_ready   = (state_q == FILL);
    assign bus.plane_valid = (state_q == SEND);
    assign bus.plane_step  = step_q;
    assign bus.plane_last  = (state_q == SEND) && (step_q == '0);
    assign bus.busy        = busy_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_lin_radix_encoder.sv
// Directed bench for lin_radix_encoder.
module tb_lin_radix_encoder;

    localparam int N = 84;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [2:0]   mdl [N];
    logic [N-1:0] exp_v;

    lin_radix_encoder_if bus ();

    lin_radix_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Expected plane from the bench's own copy of the frame.
    function automatic logic [N-1:0] exp_plane(input int s);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = mdl[i][s];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) mdl[i] = 3'd0;
    endtask

    // Offer one word; returns one step after its acceptance edge.
    task automatic drive_word(input logic [2:0] d, input logic last);
        int n;
        n = 0;
        bus.act_valid = 1'b1;
        bus.act_data  = d;
        bus.act_last  = last;
        while (!bus.act_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL act_ready_wait: got 0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        bus.act_valid = 1'b0;
        bus.act_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.act_valid = 1'b0; bus.act_data = 3'd0; bus.act_last = 1'b0;
        bus.plane_ready = 1'b0;
        #12;
        checks++; if (bus.act_ready !== 1'b1) begin errors++; $display("FAIL rst_act_ready: got %b expected 1", bus.act_ready); end
        checks++; if (bus.plane_valid !== 1'b0) begin errors++; $display("FAIL rst_plane_valid: got %b expected 0", bus.plane_valid); end
        checks++; if (bus.plane_data !== '0) begin errors++; $display("FAIL rst_plane_data: got %h expected 0", bus.plane_data); end
        checks++; if (bus.plane_step !== 2'd2) begin errors++; $display("FAIL rst_plane_step: got %0d expected 2", bus.plane_step); end
        checks++; if (bus.plane_last !== 1'b0) begin errors++; $display("FAIL rst_plane_last: got %b expected 0", bus.plane_last); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        logic [2:0] exp5, exp3;
        exp5 = 3'b101;
        exp3 = 3'b011;
        clear_model();
        bus.plane_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            mdl[i] = 3'(i % 8);
            drive_word(3'(i % 8), i == N - 1);
            if (i == 40) begin
                checks++; if (bus.plane_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL full_midfill: got valid=%b busy=%b expected valid=0 busy=1", bus.plane_valid, bus.busy); end
            end
        end
        for (int s = 2; s >= 0; s--) begin
            checks++; if (bus.plane_valid !== 1'b1) begin errors++; $display("FAIL full_valid s%0d: got %b expected 1", s, bus.plane_valid); end
            checks++; if (bus.plane_step !== 2'(s)) begin errors++; $display("FAIL full_step: got %0d expected %0d", bus.plane_step, s); end
            checks++; if (bus.plane_data[5] !== exp5[s]) begin errors++; $display("FAIL full_bit5 s%0d: got %b expected %b", s, bus.plane_data[5], exp5[s]); end
            checks++; if (bus.plane_data[3] !== exp3[s]) begin errors++; $display("FAIL full_bit3 s%0d: got %b expected %b", s, bus.plane_data[3], exp3[s]); end
            exp_v = exp_plane(s);
            checks++; if (bus.plane_data !== exp_v) begin errors++; $display("FAIL full_data s%0d: got %h expected %h", s, bus.plane_data, exp_v); end
            checks++; if (bus.plane_last !== (s == 0)) begin errors++; $display("FAIL full_last s%0d: got %b expected %b", s, bus.plane_last, (s == 0)); end
            checks++; if (bus.act_ready !== 1'b0) begin errors++; $display("FAIL full_act_ready s%0d: got %b expected 0", s, bus.act_ready); end
            @(posedge clk); #1;
        end
        checks++; if (bus.act_ready !== 1'b1 || bus.plane_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL full_return: got ready=%b valid=%b busy=%b expected 1 0 0", bus.act_ready, bus.plane_valid, bus.busy); end
    endtask

    task automatic test_short_frame();
        logic [N-1:0] one_v;
        one_v = 1;
        bus.plane_ready = 1'b1;
        drive_word(3'd7, 1'b1);
        for (int s = 2; s >= 0; s--) begin
            checks++; if (bus.plane_valid !== 1'b1 || bus.plane_step !== 2'(s)) begin errors++; $display("FAIL short_plane: got valid=%b step=%0d expected 1 %0d", bus.plane_valid, bus.plane_step, s); end
            checks++; if (bus.plane_data !== one_v) begin errors++; $display("FAIL short_data s%0d: got %h expected %h", s, bus.plane_data, one_v); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) drive_word(3'd0, i == N - 1);
        for (int s = 2; s >= 0; s--) begin
            checks++; if (bus.plane_valid !== 1'b1 || bus.plane_data !== '0) begin errors++; $display("FAIL zero_data s%0d: got valid=%b data=%h expected 1 0", s, bus.plane_valid, bus.plane_data); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        clear_model();
        bus.plane_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            mdl[i] = 3'((i * 3) % 8);
            drive_word(3'((i * 3) % 8), i == N - 1);
        end
        checks++; if (bus.plane_valid !== 1'b1 || bus.plane_step !== 2'd2) begin errors++; $display("FAIL bp_first: got valid=%b step=%0d expected 1 2", bus.plane_valid, bus.plane_step); end
        bus.plane_ready = 1'b1;
        @(posedge clk); #1;
        bus.plane_ready = 1'b0;
        bus.act_valid = 1'b1; bus.act_data = 3'd7; bus.act_last = 1'b1;
        exp_v = exp_plane(1);
        repeat (5) begin
            checks++; if (bus.plane_valid !== 1'b1 || bus.plane_step !== 2'd1 || bus.plane_last !== 1'b0) begin errors++; $display("FAIL bp_hold: got valid=%b step=%0d last=%b expected 1 1 0", bus.plane_valid, bus.plane_step, bus.plane_last); end
            checks++; if (bus.plane_data !== exp_v) begin errors++; $display("FAIL bp_data: got %h expected %h", bus.plane_data, exp_v); end
            checks++; if (bus.act_ready !== 1'b0) begin errors++; $display("FAIL bp_act_ready: got %b expected 0", bus.act_ready); end
            @(posedge clk); #1;
        end
        bus.act_valid = 1'b0; bus.act_last = 1'b0;
        bus.plane_ready = 1'b1;
        @(posedge clk); #1;
        exp_v = exp_plane(0);
        checks++; if (bus.plane_step !== 2'd0 || bus.plane_last !== 1'b1 || bus.plane_data !== exp_v) begin errors++; $display("FAIL bp_last: got step=%0d last=%b data=%h expected 0 1 %h", bus.plane_step, bus.plane_last, bus.plane_data, exp_v); end
        @(posedge clk); #1;
        checks++; if (bus.act_ready !== 1'b1 || bus.plane_valid !== 1'b0) begin errors++; $display("FAIL bp_return: got ready=%b valid=%b expected 1 0", bus.act_ready, bus.plane_valid); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ones_v, zeros_v;
        logic [2:0]   pa, pb;
        ones_v = '1; zeros_v = '0;
        pa = 3'b011;
        pb = 3'b100;
        bus.plane_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) drive_word((f == 0) ? 3'd3 : 3'd4, i == N - 1);
            for (int s = 2; s >= 0; s--) begin
                exp_v = ((f == 0) ? pa[s] : pb[s]) ? ones_v : zeros_v;
                checks++; if (bus.plane_valid !== 1'b1 || bus.plane_data !== exp_v) begin errors++; $display("FAIL b2b_data f%0d s%0d: got valid=%b data=%h expected 1 %h", f, s, bus.plane_valid, bus.plane_data, exp_v); end
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy f%0d s%0d: got %b expected 1", f, s, bus.busy); end
                @(posedge clk); #1;
            end
            checks++; if (bus.busy !== 1'b0 || bus.act_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle f%0d: got busy=%b ready=%b expected 0 1", f, bus.busy, bus.act_ready); end
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] low10_v;
        logic [2:0]   p6;
        low10_v = 84'h3FF;
        p6 = 3'b110;
        bus.plane_ready = 1'b0;
        for (int i = 0; i < N; i++) drive_word(3'd5, i == N - 1);
        bus.plane_ready = 1'b1;
        @(posedge clk); #1;
        bus.plane_ready = 1'b0;
        checks++; if (bus.plane_step !== 2'd1) begin errors++; $display("FAIL ar_pre_step: got %0d expected 1", bus.plane_step); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.plane_valid !== 1'b0 || bus.act_ready !== 1'b1) begin errors++; $display("FAIL ar_handshake: got valid=%b ready=%b expected 0 1", bus.plane_valid, bus.act_ready); end
        checks++; if (bus.plane_step !== 2'd2 || bus.plane_last !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ar_state: got step=%0d last=%b busy=%b expected 2 0 0", bus.plane_step, bus.plane_last, bus.busy); end
        checks++; if (bus.plane_data !== '0) begin errors++; $display("FAIL ar_data: got %h expected 0", bus.plane_data); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.plane_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive_word(3'd6, i == 9);
        for (int s = 2; s >= 0; s--) begin
            exp_v = p6[s] ? low10_v : '0;
            checks++; if (bus.plane_valid !== 1'b1 || bus.plane_step !== 2'(s) || bus.plane_data !== exp_v) begin errors++; $display("FAIL ar_plane s%0d: got valid=%b step=%0d data=%h expected 1 %0d %h", s, bus.plane_valid, bus.plane_step, bus.plane_data, s, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
